sd_write_para_top: RTL
======================

SD_WRITE_PARA_TOP -- requirements
Module: sd_write_para_top

Interface
REQ-001 Parameter DATA_WIDTH, 256: AXI read data width; the block supports 256 only.
REQ-002 Parameter ADDR_WIDTH, 32: AXI/DDR byte address width.
REQ-003 Parameter ID_WIDTH, 8: AXI ID width.
REQ-004 Parameter ID, 8'h41: constant driven on model_arid.
REQ-005 sys_clk  in  1  the only clock; all logic is on its rising edge.
REQ-006 rst  in  1  synchronous reset, active-high.
REQ-007 start  in  1  rising edge begins a dump job; it is ignored unless the FSM is in IDLE.
REQ-008 ddr_addr_base  in  ADDR_WIDTH  DDR source byte address, 512-byte aligned; sampled on the start edge.
REQ-009 sd_start_sec  in  32  first SD destination sector; sampled on the start edge.
REQ-010 sd_sec_num  in  32  number of sectors to write; sampled on the start edge.
REQ-011 busy  out  1  high whenever the FSM is not in IDLE.
REQ-012 done  out  1  one-cycle pulse when a job completes.
REQ-013 err  out  1  sticky flag for rresp!=OKAY; cleared by the next accepted start.
REQ-014 model_araddr/arlen/arsize/arburst/arvalid  out  AR channel; model_arready in.
REQ-015 model_arid=ID, arlock=0, arcache=4'b0011, arprot=0 are constant outputs.
REQ-016 model_rid/rdata/rresp/rlast/rvalid  in  R channel; model_rready out.
REQ-017 sd_wr_start  out  1  one-cycle pulse requesting a single-sector write.
REQ-018 sd_wr_sec_addr  out  32  target sector; stable from the sd_wr_start pulse until sd_wr_busy falls.
REQ-019 sd_wr_busy  in  1  SD write controller busy.
REQ-020 sd_wr_req  in  1  SD controller requests the next 16-bit word.
REQ-021 sd_wr_data  out  16  word for the SD controller; valid the cycle after sd_wr_req.

Function
REQ-022 The FSM has the states IDLE, AR, RD, SD_START, SD_WAIT, NEXT and FIN.
REQ-023 IDLE->AR on a start rising edge with sd_sec_num!=0; with sd_sec_num==0, IDLE->FIN.
REQ-024 AR: the block drives arvalid=1, arlen=15, arsize=3'b101 and arburst=INCR, with araddr = base + 512*sector_index; it moves to RD on arready.
REQ-025 RD: rready=1; each beat is written to the 16x256-bit sector buffer at a beat counter of 0..15; on the beat with rlast, or beat 15, the FSM moves to SD_START.
REQ-026 Any beat with rresp!=0 sets err; the beat is stored anyway and the job continues.
REQ-027 SD_START pulses sd_wr_start for one cycle, with sd_wr_sec_addr = sd_start_sec + sector_index, then the FSM moves to SD_WAIT.
REQ-028 SD_WAIT waits for sd_wr_busy to rise and then fall, then moves to NEXT.
REQ-029 On each sd_wr_req, a 0..255 word counter selects halfword k = beat k[7:4], bits [16*k[3:0]+15 : 16*k[3:0]]; the result is registered onto sd_wr_data.
REQ-030 NEXT increments sector_index; if sector_index == sd_sec_num-1 the FSM moves to FIN, else to AR.
REQ-031 FIN pulses done for one cycle and returns to IDLE.
REQ-032 An sd_wr_req received after word 255 holds sd_wr_data at its last value, and the word counter does not wrap.
REQ-033 A start edge while busy is ignored, and the sampled job parameters do not change.
REQ-034 sector_index and the address arithmetic are 32-bit unsigned; araddr wraps modulo 2^ADDR_WIDTH.

Reset
REQ-035 While rst=1: FSM=IDLE; busy, done, err, arvalid, rready and sd_wr_start are 0; sd_wr_data is 0; all counters are 0.
REQ-036 Reset mid-job aborts the job immediately without a done pulse; no AXI transaction is completed afterward.

Structure
REQ-037 A shared package holds the FSM state enum, SECTOR_BYTES=512, BEATS_PER_SECTOR=16 and WORDS_PER_SECTOR=256.
REQ-038 The sector buffer is the sub-module sd_sector_buf: 16x256-bit, one write port, and a registered read port with a 16-bit mux.

Verification
REQ-039 base=0x1000, sec=100, num=1, beat i=i-replicated pattern -> araddr=0x1000, arlen=15, sd_wr_sec_addr=100, 256 words in halfword order, done=1 once.
REQ-040 num=3 -> araddr 0x1000, 0x1200, 0x1400; sd_wr_sec_addr 100, 101, 102; exactly 3 sd_wr_start pulses.
REQ-041 num=0 -> no arvalid, no sd_wr_start; done pulses within 2 cycles of start.
REQ-042 rresp=2'b10 on beat 5 -> err=1; 256 words are still written; done=1.
REQ-043 arready held low for 20 cycles, and rvalid gaps -> arvalid stays high and stable; data is still correct.
REQ-044 rst asserted during SD_WAIT -> all outputs take reset values next cycle; no done; a new start then runs a full job.

Source files
------------

// File: rtl/sd_write_para_pkg.sv
// sd_write_para_pkg: shared FSM state encoding and sector geometry constants
package sd_write_para_pkg;
  typedef enum logic [2:0] {S_IDLE, S_AR, S_RD, S_SD_START, S_SD_WAIT, S_NEXT, S_FIN} state_t;
  localparam int SECTOR_BYTES = 512;
  localparam int BEATS_PER_SECTOR = 16;
  localparam int WORDS_PER_SECTOR = 256;
endpackage

// File: rtl/sd_sector_buf.sv
// sd_sector_buf: 16x256-bit sector buffer, beat-wide write, registered halfword read
module sd_sector_buf
  import sd_write_para_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [3:0]   waddr,
  input  logic [255:0] wdata,
  input  logic         re,
  input  logic [7:0]   raddr,
  output logic [15:0]  rdata
);
  logic [255:0] mem [BEATS_PER_SECTOR];
  // store one AXI beat per write
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  // upper nibble picks the beat, lower nibble the halfword; holds when not reading
  always_ff @(posedge clk)
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[raddr[7:4]][{raddr[3:0], 4'd0} +: 16];
endmodule

// File: rtl/sd_write_para_top.sv
// sd_write_para_top: dumps DDR sectors over AXI read into single-sector SD writes
module sd_write_para_top
  import sd_write_para_pkg::*;
#(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH = 8,
  parameter logic [ID_WIDTH-1:0] ID = 8'h41
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] ddr_addr_base,
  input  logic [31:0]           sd_start_sec,
  input  logic [31:0]           sd_sec_num,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ID_WIDTH-1:0]   model_arid,
  output logic [ADDR_WIDTH-1:0] model_araddr,
  output logic [7:0]            model_arlen,
  output logic [2:0]            model_arsize,
  output logic [1:0]            model_arburst,
  output logic                  model_arlock,
  output logic [3:0]            model_arcache,
  output logic [2:0]            model_arprot,
  output logic                  model_arvalid,
  input  logic                  model_arready,
  input  logic [ID_WIDTH-1:0]   model_rid,
  input  logic [DATA_WIDTH-1:0] model_rdata,
  input  logic [1:0]            model_rresp,
  input  logic                  model_rlast,
  input  logic                  model_rvalid,
  output logic                  model_rready,
  output logic                  sd_wr_start,
  output logic [31:0]           sd_wr_sec_addr,
  input  logic                  sd_wr_busy,
  input  logic                  sd_wr_req,
  output logic [15:0]           sd_wr_data
);
  state_t state, nxt;
  logic start_d, seen_busy;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [31:0] ssec_q, num_q, sec_idx;
  logic [3:0] bcnt;
  logic [8:0] wcnt;
  logic start_rise, beat, buf_re, unused_rid;
  assign unused_rid = ^model_rid;
  assign start_rise = start & ~start_d;
  assign beat = state == S_RD && model_rvalid;
  assign buf_re = state == S_SD_WAIT && sd_wr_req && wcnt < 9'(WORDS_PER_SECTOR);
  assign busy = state != S_IDLE;
  assign done = state == S_FIN;
  assign model_arid = ID;
  assign model_arlock = 1'b0;
  assign model_arcache = 4'b0011;
  assign model_arprot = 3'b000;
  assign model_arlen = 8'(BEATS_PER_SECTOR - 1);
  assign model_arsize = 3'b101;
  assign model_arburst = 2'b01;
  assign model_arvalid = state == S_AR;
  assign model_araddr = base_q + ADDR_WIDTH'(sec_idx) * ADDR_WIDTH'(SECTOR_BYTES);
  assign model_rready = state == S_RD;
  assign sd_wr_start = state == S_SD_START;
  assign sd_wr_sec_addr = ssec_q + sec_idx;
  // state register, job parameters and counters
  always_ff @(posedge sys_clk)
    if (rst) begin
      state <= S_IDLE;
      start_d <= 1'b0;
      seen_busy <= 1'b0;
      err <= 1'b0;
      base_q <= '0;
      ssec_q <= '0;
      num_q <= '0;
      sec_idx <= '0;
      bcnt <= '0;
      wcnt <= '0;
    end else begin
      state <= nxt;
      start_d <= start;
      if (state == S_IDLE && start_rise) begin
        base_q <= ddr_addr_base;
        ssec_q <= sd_start_sec;
        num_q <= sd_sec_num;
        sec_idx <= '0;
        err <= 1'b0;
      end
      if (state == S_AR) bcnt <= '0;
      if (beat) bcnt <= bcnt + 4'd1;
      if (beat && model_rresp != 2'b00) err <= 1'b1;
      if (buf_re) wcnt <= wcnt + 9'd1;
      if (state == S_SD_WAIT && sd_wr_busy) seen_busy <= 1'b1;
      if (state == S_SD_START) begin
        wcnt <= '0;
        seen_busy <= 1'b0;
      end
      if (state == S_NEXT) sec_idx <= sec_idx + 32'd1;
    end
  // next-state logic; a short burst (early rlast) still ends the sector
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:     if (start_rise) nxt = sd_sec_num == 32'd0 ? S_FIN : S_AR;
      S_AR:       if (model_arready) nxt = S_RD;
      S_RD:       if (beat && (model_rlast || bcnt == 4'(BEATS_PER_SECTOR - 1))) nxt = S_SD_START;
      S_SD_START: nxt = S_SD_WAIT;
      S_SD_WAIT:  if (seen_busy && !sd_wr_busy) nxt = S_NEXT;
      S_NEXT:     nxt = sec_idx == num_q - 32'd1 ? S_FIN : S_AR;
      S_FIN:      nxt = S_IDLE;
      default:    nxt = S_IDLE;
    endcase
  end
  sd_sector_buf u_buf (
    .clk(sys_clk),
    .rst(rst),
    .we(beat),
    .waddr(bcnt),
    .wdata(model_rdata),
    .re(buf_re),
    .raddr(wcnt[7:0]),
    .rdata(sd_wr_data)
  );
endmodule
